ps2_keyboard: RTL and testbench
===============================

// Module: ps2_keyboard
// PURPOSE
//  PS/2 keyboard receiver and scan-code set-2 decoder, feeding the zx core's keyboard strb/make/code inputs.
//  Synchronises and debounces raw ps2ck/ps2d, deserialises 11-bit frames and checks odd parity and the stop bit.
//  Folds the E0/F0 prefixes into a single key event.
//  Device-to-host only: never drives the PS/2 lines.
// PARAMETERS
//  FILTER   8       consecutive identical ps2ck samples needed to accept a new level (glitch filter)
//  TIMEOUT  112000  clock cycles (2 ms @ 56 MHz) without a ps2ck fall before a partial frame is aborted
// PORTS
//  clock  in   1  system clock, 56 MHz
//  reset  in   1  asynchronous, active-low reset
//  ps2ck  in   1  raw PS/2 clock (open-collector, idle high)
//  ps2d   in   1  raw PS/2 data
//  strb   out  1  one-cycle pulse: new key event on make/code/ext
//  make   out  1  1 = key pressed, 0 = key released
//  code   out  8  scan code, set 2, prefixes removed
//  ext    out  1  1 = event was E0-prefixed
//  err    out  1  one-cycle pulse: parity or stop-bit error
// BEHAVIOUR
//  Reset: strb=0, make=0, code=0, ext=0, err=0; state IDLE; prefix flags cleared; filter level=1.
//    Asynchronous reset mid-frame discards the partial frame.
//  Input conditioning
//    - ps2ck and ps2d each pass through a 2-FF synchroniser.
//    - Filtered ps2ck changes level only after FILTER equal consecutive samples.
//    - fall = filtered 1->0 transition, lasting one cycle.
//    - Data is sampled from synchronised ps2d in the fall cycle.
//  FSM (advances only on fall)
//    - IDLE: ps2d=0 -> DATA with bit counter 0; ps2d=1 -> stay in IDLE (spurious edge ignored).
//    - DATA: shift LSB first; after 8th bit -> PARITY.
//    - PARITY: latch bit -> STOP.
//    - STOP: frame OK iff ^{data,parity}=1 and stop=1; -> IDLE in either case.
//  Bad frame: err pulses at N+1 (N = stop-bit fall cycle); byte dropped; prefix flags cleared; no strb.
//  Good frame, byte B, decoded at N+1:
//    - B=E0: set ext flag, no strb.
//    - B=F0: set brk flag, no strb.
//    - B=E1: ignored, flags unchanged.
//    - B in {00,AA,EE,FA,FC,FE,FF} with no flag set: discarded (BAT/ack/overrun).
//    - Any other B: strb=1 for exactly cycle N+1; code=B, make=!brk, ext=ext flag; both flags then cleared.
//  code/make/ext are updated only together with strb and hold until the next strb.
//  strb and err are never asserted in the same cycle.
//  Prefixes survive between frames indefinitely (no timeout applies to flags).
// CONFIGURATION
//  PS2K_TIMEOUT_EN defined:
//    - A cycle counter runs while state!=IDLE and restarts on every fall.
//    - On reaching TIMEOUT: state->IDLE, bit counter cleared, partial byte dropped.
//    - No err pulse; prefix flags are kept.
//  PS2K_TIMEOUT_EN undefined: no counter; a partial frame waits indefinitely for further edges.
// STRUCTURE
//  ps2k_pkg: FSM state enum (IDLE, DATA, PARITY, STOP); byte constants PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1;
//    discard list 00/AA/EE/FA/FC/FE/FF.
//  Sub-module ps2_filter: 2-FF synchroniser plus FILTER-deep level debouncer; outputs level and fall.
//    Used once for ps2ck. ps2d is only synchronised inline.
//  Top: frame FSM, shift register, optional timeout counter, prefix/decode logic.
// TESTING
//  Bit period 80 us, FILTER=8. Frames are start, 8 data bits LSB first, odd parity, stop.
//  1 frame 1C, parity 0 -> one strb, make=1, code=1C, ext=0, err never asserted.
//  2 frames F0,1C -> exactly one strb (after 2nd frame), make=0, code=1C, ext=0.
//  3 frames E0,F0,75 -> one strb, make=0, code=75, ext=1; then frame 75 -> strb, make=1, ext=0.
//  4 frame 1C with parity 1 -> err pulse, no strb; E0 before bad frame is cleared;
//    next good 1C -> ext=0, make=1.
//  5 frame AA after reset -> no strb, no err; 3-cycle low glitch on ps2ck while idle -> no state change.
//  6 (PS2K_TIMEOUT_EN) 5 bits, then ps2ck held high >TIMEOUT, then full frame 29
//    -> one strb, code=29, make=1.
//  7 reset asserted mid-frame (after 4 bits), then full frame 29 -> one strb, code=29; outputs 0 during reset.

Source files
------------

// File: rtl/ps2k_pkg.sv
// Shared types and byte constants for the PS/2 keyboard receiver.
// The optional frame timeout is compiled in with PS2K_TIMEOUT_EN.
`timescale 1ns/1ps
package ps2k_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2k_state_e;

  typedef struct packed {
    ps2k_state_e state;
    logic        ck_level;
    logic [2:0]  bit_cnt;
  } ps2k_dbg_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // BAT result, echo, ack, self-test fail, resend and overrun bytes are not keys
  function automatic logic is_discard(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// 2-FF synchroniser plus level debouncer for the raw PS/2 clock.
// The level only moves after FILTER consecutive samples disagree with it.
`timescale 1ns/1ps
module ps2_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILTER > 2) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      fall_d  = level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 receiver: frame FSM, parity/stop check and E0/F0 prefix folding.
// Define PS2K_TIMEOUT_EN to abort stalled frames after TIMEOUT cycles.
`timescale 1ns/1ps
module ps2_keyboard
  import ps2k_pkg::*;
#(
  parameter int FILTER = 8
`ifdef PS2K_TIMEOUT_EN
  , parameter int TIMEOUT = 112000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err,
  output ps2k_dbg_t  dbg_o
);

  logic ck_level, ck_fall;
  logic [1:0] d_sync_q;
  logic d_s;

  ps2_filter #(.FILTER(FILTER)) u_ck_filter (
    .clock   (clock),
    .reset   (reset),
    .raw_i   (ps2ck),
    .level_o (ck_level),
    .fall_o  (ck_fall)
  );

  assign d_s = d_sync_q[1];

  ps2k_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       ext_flag_q, ext_flag_d;
  logic       brk_flag_q, brk_flag_d;
  logic       strb_q, strb_d;
  logic       err_q, err_d;
  logic       make_q, make_d;
  logic       ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic       frame_ok;

`ifdef PS2K_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          to_cnt_q <= '0;
    else if (state_q == IDLE || ck_fall) to_cnt_q <= '0;
    else                                 to_cnt_q <= to_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ext_flag_d = ext_flag_q;
    brk_flag_d = brk_flag_q;
    strb_d     = 1'b0;
    err_d      = 1'b0;
    make_d     = make_q;
    ext_d      = ext_q;
    code_d     = code_q;
    frame_ok   = (^{shift_q, par_q}) & d_s;
    if (ck_fall) begin
      unique case (state_q)
        IDLE: begin
          if (!d_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {d_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = d_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!frame_ok) begin
            err_d      = 1'b1;
            ext_flag_d = 1'b0;
            brk_flag_d = 1'b0;
          end else if (shift_q == PFX_EXT) begin
            ext_flag_d = 1'b1;
          end else if (shift_q == PFX_BRK) begin
            brk_flag_d = 1'b1;
          end else if (shift_q == PFX_PAUSE) begin
            ext_flag_d = ext_flag_q;
          end else if (!ext_flag_q && !brk_flag_q && is_discard(shift_q)) begin
            ext_flag_d = 1'b0;
          end else begin
            strb_d     = 1'b1;
            code_d     = shift_q;
            make_d     = !brk_flag_q;
            ext_d      = ext_flag_q;
            ext_flag_d = 1'b0;
            brk_flag_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2K_TIMEOUT_EN
    // Stalled frame: drop it silently, the prefix flags stay as they were
    else if (state_q != IDLE && to_cnt_q == TO_MAX) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_sync_q   <= 2'b11;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ext_flag_q <= 1'b0;
      brk_flag_q <= 1'b0;
      strb_q     <= 1'b0;
      err_q      <= 1'b0;
      make_q     <= 1'b0;
      ext_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      d_sync_q   <= {d_sync_q[0], ps2d};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ext_flag_q <= ext_flag_d;
      brk_flag_q <= brk_flag_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
      make_q     <= make_d;
      ext_q      <= ext_d;
      code_q     <= code_d;
    end
  end

  assign strb = strb_q;
  assign err  = err_q;
  assign make = make_q;
  assign ext  = ext_q;
  assign code = code_q;

  assign dbg_o.state    = state_q;
  assign dbg_o.ck_level = ck_level;
  assign dbg_o.bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard; bit period is shortened to HALF*2 clocks.
// Key events are queued as {make, ext, code} and popped when strb fires.
`timescale 1ns/1ps
module tb_ps2_keyboard;
  import ps2k_pkg::*;

  localparam int HALF = 20;
`ifdef PS2K_TIMEOUT_EN
  localparam int TMO = 300;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2ck = 1'b1;
  logic       ps2d  = 1'b1;
  logic       strb, make, ext, err;
  logic [7:0] code;
  ps2k_dbg_t  dbg_o;

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int err_exp     = 0;
  logic [9:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;

`ifdef PS2K_TIMEOUT_EN
  ps2_keyboard #(.FILTER(8), .TIMEOUT(TMO)) dut (
`else
  ps2_keyboard #(.FILTER(8)) dut (
`endif
    .clock (clock),
    .reset (reset),
    .ps2ck (ps2ck),
    .ps2d  (ps2d),
    .strb  (strb),
    .make  (make),
    .code  (code),
    .ext   (ext),
    .err   (err),
    .dbg_o (dbg_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wait_cyc(HALF);
      ps2ck = 1'b0;
      wait_cyc(HALF);
      ps2ck = 1'b1;
    end
    wait_cyc(HALF);
    ps2d = 1'b1;
    wait_cyc(60);
  endtask

  task automatic expect_key(input logic mk, input logic ex, input logic [7:0] cd);
    exp_q.push_back({mk, ex, cd});
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_errs"}, err_seen, err_exp);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (err) err_seen++;
    if (strb || err) check("strb_err_excl", {31'd0, strb & err}, 0);
    if (strb) begin
      if (exp_q.size() == 0) begin
        check("strb_unexpected", {31'd0, strb}, 0);
      end else begin
        check("key_event", {22'd0, make, ext, code}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(5);
    check("rst_strb", strb, 0);
    check("rst_make", make, 0);
    check("rst_code", code, 0);
    check("rst_ext", ext, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_o.state, IDLE);
    check("rst_ck_level", dbg_o.ck_level, 1);
    reset = 1'b1;
    wait_cyc(10);

    // 1: plain make
    expect_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 11);
    drain_check("t1");

    // 2: break
    expect_key(1'b0, 1'b0, 8'h1C);
    send_frame(8'hF0, 1'b0, 11);
    check("t2_no_early_strb", exp_q.size(), 1);
    send_frame(8'h1C, 1'b0, 11);
    drain_check("t2");

    // 3: extended break then plain make
    expect_key(1'b0, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    drain_check("t3a");
    expect_key(1'b1, 1'b0, 8'h75);
    send_frame(8'h75, 1'b0, 11);
    drain_check("t3b");

    // 4: parity error clears pending E0
    send_frame(8'hE0, 1'b0, 11);
    err_exp++;
    send_frame(8'h1C, 1'b1, 11);
    drain_check("t4_bad");
    check("t4_hold_code", code, 8'h75);
    expect_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 11);
    drain_check("t4");

    // 5: BAT byte after reset, then a short glitch while idle
    reset = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(5);
    send_frame(8'hAA, 1'b0, 11);
    drain_check("t5_bat");
    check("t5_code_zero", code, 0);
    ps2ck = 1'b0;
    wait_cyc(3);
    ps2ck = 1'b1;
    wait_cyc(20);
    check("t5_glitch_state", dbg_o.state, IDLE);
    check("t5_glitch_level", dbg_o.ck_level, 1);
    expect_key(1'b1, 1'b0, 8'h16);
    send_frame(8'h16, 1'b0, 11);
    drain_check("t5");

`ifdef PS2K_TIMEOUT_EN
    // 6: stalled frame is abandoned
    send_frame(8'h29, 1'b0, 5);
    check("t6_partial_state", dbg_o.state, DATA);
    wait_cyc(TMO + 50);
    check("t6_timeout_state", dbg_o.state, IDLE);
    expect_key(1'b1, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0, 11);
    drain_check("t6");
`endif

    // 7: reset mid-frame
    send_frame(8'h29, 1'b0, 4);
    check("t7_partial_state", dbg_o.state, DATA);
    reset = 1'b0;
    wait_cyc(3);
    check("t7_rst_code", code, 0);
    check("t7_rst_make", make, 0);
    check("t7_rst_state", dbg_o.state, IDLE);
    reset = 1'b1;
    wait_cyc(5);
    expect_key(1'b1, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0, 11);
    drain_check("t7");
    check("t7_hold_code", code, 8'h29);
    check("t7_hold_make", make, 1);
    check("t7_hold_ext", ext, 0);

    wait_cyc(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
